// File: rtl/multi_block_sprite.sv
// Multi-rectangle sprite renderer: frame-latched shadow registers, per-block blink,
// 2-stage pipeline (registered hit vector, then priority select and colour).
module multi_block_sprite #(
  parameter int NUM_BLOCKS   = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int FCW          = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic                     new_frame_in,
  input  logic [12*NUM_BLOCKS-1:0] x_in,
  input  logic [11*NUM_BLOCKS-1:0] y_in,
  input  logic [12*NUM_BLOCKS-1:0] xmax_in,
  input  logic [11*NUM_BLOCKS-1:0] ymax_in,
  input  logic [24*NUM_BLOCKS-1:0] color_in,
  input  logic [NUM_BLOCKS-1:0]    enable_in,
  input  logic [NUM_BLOCKS-1:0]    blink_in,
  output logic [7:0]               red_out,
  output logic [7:0]               green_out,
  output logic [7:0]               blue_out,
  output logic                     hit_out,
  output logic [3:0]               hit_idx_out
);

  logic [12*NUM_BLOCKS-1:0] x_sh, xmax_sh;
  logic [11*NUM_BLOCKS-1:0] y_sh, ymax_sh;
  logic [24*NUM_BLOCKS-1:0] color_sh, color_s1;
  logic [NUM_BLOCKS-1:0]    enable_sh, blink_sh;
  logic [NUM_BLOCKS-1:0]    hit_next, hit_s1;
  logic [FCW-1:0]           frame_cnt;
  logic                     hidden;

  logic                     win_hit;
  logic [3:0]               win_idx;
  logic [23:0]              win_color;

  logic [11:0]              h12, v12;

  assign h12 = {1'b0, hcount_in};
  assign v12 = {2'b0, vcount_in};

  // Shadow registers and blink phase only move on the frame pulse, so a frame never tears.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_sh      <= '0;
      y_sh      <= '0;
      xmax_sh   <= '0;
      ymax_sh   <= '0;
      color_sh  <= '0;
      enable_sh <= '0;
      blink_sh  <= '0;
      frame_cnt <= '0;
      hidden    <= 1'b0;
    end else if (new_frame_in) begin
      x_sh      <= x_in;
      y_sh      <= y_in;
      xmax_sh   <= xmax_in;
      ymax_sh   <= ymax_in;
      color_sh  <= color_in;
      enable_sh <= enable_in;
      blink_sh  <= blink_in;
      if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        hidden    <= ~hidden;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Half-open interval test; an empty or inverted rectangle can never satisfy both bounds.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit_next = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      hit_next[i] = enable_sh[i] && !(blink_sh[i] && hidden)
                 && (h12 >= x_sh[12*i +: 12]) && (h12 < xmax_sh[12*i +: 12])
                 && (v12 >= {1'b0, y_sh[11*i +: 11]})
                 && (v12 < {1'b0, ymax_sh[11*i +: 11]});
    end
  end

  // Colours travel with the hit vector so a frame pulse between stages cannot recolour a pixel.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_s1   <= '0;
      color_s1 <= '0;
    end else begin
      hit_s1   <= hit_next;
      color_s1 <= color_sh;
    end
  end

  // Scan from the top down so the lowest hitting index is the last one written.
  always_comb begin
    win_hit   = 1'b0;
    win_idx   = '0;
    win_color = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        win_hit   = 1'b1;
        win_idx   = 4'(i);
        win_color = color_s1[24*i +: 24];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      hit_out     <= 1'b0;
      hit_idx_out <= '0;
    end else begin
      red_out     <= win_color[23:16];
      green_out   <= win_color[15:8];
      blue_out    <= win_color[7:0];
      hit_out     <= win_hit;
      hit_idx_out <= win_idx;
    end
  end

endmodule

// File: tb/tb_multi_block_sprite.sv
// Self-checking bench for multi_block_sprite: directed scenarios plus randomized frames,
// each compared against a frame-level behavioural model of the renderer.
module tb_multi_block_sprite;

  localparam int NB  = 4;
  localparam int BF  = 2;
  localparam int FCW = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [10:0]       hcount_in = '0;
  logic [9:0]        vcount_in = '0;
  logic              new_frame_in = 1'b0;
  logic [12*NB-1:0]  x_in = '0;
  logic [11*NB-1:0]  y_in = '0;
  logic [12*NB-1:0]  xmax_in = '0;
  logic [11*NB-1:0]  ymax_in = '0;
  logic [24*NB-1:0]  color_in = '0;
  logic [NB-1:0]     enable_in = '0;
  logic [NB-1:0]     blink_in = '0;
  logic [7:0]        red_out, green_out, blue_out;
  logic              hit_out;
  logic [3:0]        hit_idx_out;

  multi_block_sprite #(.NUM_BLOCKS(NB), .BLINK_FRAMES(BF), .FCW(FCW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .new_frame_in(new_frame_in), .x_in(x_in), .y_in(y_in), .xmax_in(xmax_in),
    .ymax_in(ymax_in), .color_in(color_in), .enable_in(enable_in), .blink_in(blink_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hit_out(hit_out), .hit_idx_out(hit_idx_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model state: what the bench is driving (pending) and what the current frame shows (shadow).
  int p_x[NB], p_y[NB], p_xm[NB], p_ym[NB], p_col[NB], p_en[NB], p_bl[NB];
  int s_x[NB], s_y[NB], s_xm[NB], s_ym[NB], s_col[NB], s_en[NB], s_bl[NB];
  int pulses = 0;

  function automatic logic [28:0] observed();
    return {hit_out, hit_idx_out, red_out, green_out, blue_out};
  endfunction

  // Blocks with the blink bit are hidden in every odd-numbered run of BF frames since reset.
  function automatic logic [28:0] expect_px(int h, int v);
    bit hid;
    hid = ((pulses / BF) % 2) == 1;
    for (int i = 0; i < NB; i++) begin
      if (s_en[i] != 0 && !(s_bl[i] != 0 && hid) && h >= s_x[i] && h < s_xm[i]
          && v >= s_y[i] && v < s_ym[i])
        return {1'b1, 4'(i), 24'(s_col[i])};
    end
    return '0;
  endfunction

  task automatic check(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      s_x[i] = 0; s_y[i] = 0; s_xm[i] = 0; s_ym[i] = 0;
      s_col[i] = 0; s_en[i] = 0; s_bl[i] = 0;
    end
    pulses = 0;
  endtask

  task automatic set_block(input int i, input int x, input int y, input int xm, input int ym,
                           input int col, input int en, input int bl);
    p_x[i] = x; p_y[i] = y; p_xm[i] = xm; p_ym[i] = ym;
    p_col[i] = col; p_en[i] = en; p_bl[i] = bl;
    x_in[12*i +: 12]     = 12'(x);
    y_in[11*i +: 11]     = 11'(y);
    xmax_in[12*i +: 12]  = 12'(xm);
    ymax_in[11*i +: 11]  = 11'(ym);
    color_in[24*i +: 24] = 24'(col);
    enable_in[i]         = (en != 0);
    blink_in[i]          = (bl != 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // Single pixel through the pipeline: driven at a negedge, sampled two posedges later.
  task automatic probe(input int h, input int v, input string tag);
    logic [28:0] exp;
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    exp = expect_px(h, v);
    @(negedge clk_in);
    @(negedge clk_in);
    check(tag, observed(), exp);
  endtask

  // Frame pulse carrying a pixel that must still render with the previous frame's shadows.
  task automatic pulse_frame(input int h, input int v, input string tag);
    logic [28:0] exp;
    @(negedge clk_in);
    hcount_in    = 11'(h);
    vcount_in    = 10'(v);
    new_frame_in = 1'b1;
    exp = expect_px(h, v);
    @(negedge clk_in);
    new_frame_in = 1'b0;
    for (int i = 0; i < NB; i++) begin
      s_x[i] = p_x[i]; s_y[i] = p_y[i]; s_xm[i] = p_xm[i]; s_ym[i] = p_ym[i];
      s_col[i] = p_col[i]; s_en[i] = p_en[i]; s_bl[i] = p_bl[i];
    end
    pulses++;
    @(negedge clk_in);
    check(tag, observed(), exp);
  endtask

  initial begin
    logic [28:0] q[$];
    int h, v;

    for (int i = 0; i < NB; i++) begin
      p_x[i] = 0; p_y[i] = 0; p_xm[i] = 0; p_ym[i] = 0; p_col[i] = 0; p_en[i] = 0; p_bl[i] = 0;
    end
    model_reset();

    // Reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_outputs", observed(), 29'd0);
    rst_in = 1'b0;

    // 1: single red block, sweep row 55 across both edges
    set_block(0, 100, 50, 110, 60, 32'hFF0000, 1, 0);
    pulse_frame(105, 55, "pre_latch_pixel");
    for (int hh = 99; hh <= 110; hh++) probe(hh, 55, "row55_sweep");
    probe(105, 55, "red_inside");
    check("red_const", observed(), {1'b1, 4'd0, 24'hFF0000});
    probe(105, 49, "above_top");
    probe(105, 60, "ymax_exclusive");

    // 2: overlap, lower index wins
    set_block(0, 0, 0, 20, 100, 32'h00FF00, 1, 0);
    set_block(2, 10, 0, 30, 100, 32'h0000FF, 1, 0);
    pulse_frame(105, 55, "old_frame_on_pulse");
    probe(15, 10, "overlap_green");
    check("overlap_green_const", observed(), {1'b1, 4'd0, 24'h00FF00});
    probe(25, 10, "overlap_blue");
    check("overlap_blue_const", observed(), {1'b1, 4'd2, 24'h0000FF});
    probe(30, 10, "overlap_right_edge");

    // 3: tearing, inputs move mid-frame without a pulse
    set_block(2, 0, 0, 0, 0, 0, 0, 0);
    set_block(0, 100, 50, 110, 60, 32'hFF0000, 1, 0);
    pulse_frame(0, 0, "tear_setup_pulse");
    set_block(0, 200, 50, 210, 60, 32'hFF0000, 1, 0);
    probe(105, 55, "tear_still_old");
    probe(205, 55, "tear_new_not_yet");
    pulse_frame(105, 55, "tear_pulse_pixel_old");
    probe(105, 55, "tear_old_gone");
    probe(205, 55, "tear_new_visible");
    check("tear_new_const", observed(), {1'b1, 4'd0, 24'hFF0000});

    // 4: blink over several frames; block1 never blinks
    do_reset();
    set_block(0, 0, 0, 20, 10, 32'hFF0000, 1, 1);
    set_block(1, 40, 0, 50, 10, 32'h00FF00, 1, 0);
    for (int f = 0; f < 6; f++) begin
      pulse_frame(5, 5, "blink_pulse");
      probe(5, 5, "blink_block");
      probe(45, 5, "steady_block");
    end

    // 5: degenerate and disabled blocks
    do_reset();
    set_block(0, 300, 0, 300, 100, 32'hFFFFFF, 1, 0);
    set_block(1, 0, 80, 400, 70, 32'h123456, 1, 0);
    set_block(2, 500, 0, 600, 100, 32'hABCDEF, 0, 0);
    set_block(3, 3000, 0, 100, 100, 32'h777777, 1, 0);
    pulse_frame(0, 0, "degen_pulse");
    probe(300, 50, "zero_width");
    probe(299, 50, "zero_width_left");
    probe(100, 75, "inverted_y");
    probe(550, 50, "disabled_block");
    probe(50, 50, "no_wrap");
    check("degen_const", observed(), 29'd0);

    // 6: reset during an active hit
    set_block(0, 100, 50, 110, 60, 32'hFF0000, 1, 0);
    pulse_frame(0, 0, "pre_reset_pulse");
    @(negedge clk_in);
    hcount_in = 11'd105;
    vcount_in = 10'd55;
    @(negedge clk_in);
    @(negedge clk_in);
    check("hit_before_reset", observed(), {1'b1, 4'd0, 24'hFF0000});
    rst_in = 1'b1;
    @(negedge clk_in);
    check("outputs_after_reset_edge", observed(), 29'd0);
    rst_in = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      check("no_hit_before_frame", observed(), 29'd0);
    end
    pulse_frame(105, 55, "first_pulse_after_reset");
    probe(105, 55, "hit_after_first_frame");

    // Randomized frames with a pixel streamed every cycle
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NB; i++) begin
        h = $urandom_range(0, 60);
        v = $urandom_range(0, 60);
        set_block(i, h, v, h + $urandom_range(0, 30) - 2, v + $urandom_range(0, 30) - 2,
                  $urandom_range(0, 32'h00FFFFFF), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1));
        if (p_xm[i] < 0) set_block(i, p_x[i], p_y[i], 0, p_ym[i], p_col[i], p_en[i], p_bl[i]);
        if (p_ym[i] < 0) set_block(i, p_x[i], p_y[i], p_xm[i], 0, p_col[i], p_en[i], p_bl[i]);
      end
      pulse_frame($urandom_range(0, 80), $urandom_range(0, 80), "rand_pulse");
      q.delete();
      for (int c = 0; c < 150; c++) begin
        @(negedge clk_in);
        if (q.size() == 2) check("rand_stream", observed(), q.pop_front());
        h = $urandom_range(0, 90);
        v = $urandom_range(0, 90);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        q.push_back(expect_px(h, v));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
